// File: rtl/rf_ex_pipe.sv
// ---------------------------------------------------------------------------
// rf_ex_pipe
//
// Pipeline register between the RF stage and the EX stage. Captures operands,
// immediate, register indices and the packed control bundle from RF and
// presents them to EX one cycle later.
//
// A 2-entry skid buffer (main entry M drives the outputs, skid entry S
// absorbs one extra instruction) lets in_ready come straight from a flop, so
// there is no combinational path from out_ready back to in_ready.
//
// Ports
//   clk, rst              single clock, synchronous active-high reset
//   in_valid / in_ready   RF-side handshake (in_ready is registered)
//   pc_in .. imm_eff_in   RF-stage payload words (DW bits each)
//   ra_in .. rf_waddr_in  register indices (RW bits each)
//   ctl_in                packed control bundle (CTL_W bits)
//   flush                 kill every held and incoming instruction
//   out_valid / out_ready EX-side handshake
//   pc_out .. ctl_out     held payload; ctl_out forced to zero when nothing
//                         valid is held, data/indices keep their last values
//
// Optional build macro RF_EX_PIPE_PERF_EN adds two 16-bit wrapping counters:
//   stall_cnt   cycles with out_valid & ~out_ready
//   bubble_cnt  cycles with out_valid low while not in reset
// ---------------------------------------------------------------------------
module rf_ex_pipe #(
    parameter int DW    = 16,
    parameter int RW    = 3,
    parameter int CTL_W = 27
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    pc_in,
    input  logic [DW-1:0]    pc2_in,
    input  logic [DW-1:0]    opA_in,
    input  logic [DW-1:0]    opB_in,
    input  logic [DW-1:0]    store_data_in,
    input  logic [DW-1:0]    imm_eff_in,
    input  logic [RW-1:0]    ra_in,
    input  logic [RW-1:0]    rb_in,
    input  logic [RW-1:0]    rc_in,
    input  logic [RW-1:0]    rf_waddr_in,
    input  logic [CTL_W-1:0] ctl_in,

    input  logic             flush,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    pc_out,
    output logic [DW-1:0]    pc2_out,
    output logic [DW-1:0]    opA_out,
    output logic [DW-1:0]    opB_out,
    output logic [DW-1:0]    store_data_out,
    output logic [DW-1:0]    imm_eff_out,
    output logic [RW-1:0]    ra_out,
    output logic [RW-1:0]    rb_out,
    output logic [RW-1:0]    rc_out,
    output logic [RW-1:0]    rf_waddr_out,
    output logic [CTL_W-1:0] ctl_out
`ifdef RF_EX_PIPE_PERF_EN
    ,
    output logic [15:0]      stall_cnt,
    output logic [15:0]      bubble_cnt
`endif
);

    // One full instruction payload; both entries store a complete copy.
    typedef struct packed {
        logic [DW-1:0]    pc;
        logic [DW-1:0]    pc2;
        logic [DW-1:0]    opa;
        logic [DW-1:0]    opb;
        logic [DW-1:0]    store_data;
        logic [DW-1:0]    imm_eff;
        logic [RW-1:0]    ra;
        logic [RW-1:0]    rb;
        logic [RW-1:0]    rc;
        logic [RW-1:0]    rf_waddr;
        logic [CTL_W-1:0] ctl;
    } entry_t;

    // Encoding chosen so bit 0 is M valid and bit 1 is S valid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } state_e;

    state_e state_q, state_d;
    entry_t m_q, m_d;
    entry_t s_q, s_d;
    logic   in_ready_q, in_ready_d;
    entry_t in_ent;

    logic   m_valid;
    logic   accept;
    logic   drain;

`ifdef RF_EX_PIPE_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] bubble_cnt_q, bubble_cnt_d;
`endif

    always_comb begin
        in_ent.pc         = pc_in;
        in_ent.pc2        = pc2_in;
        in_ent.opa        = opA_in;
        in_ent.opb        = opB_in;
        in_ent.store_data = store_data_in;
        in_ent.imm_eff    = imm_eff_in;
        in_ent.ra         = ra_in;
        in_ent.rb         = rb_in;
        in_ent.rc         = rc_in;
        in_ent.rf_waddr   = rf_waddr_in;
        in_ent.ctl        = ctl_in;
    end

    assign m_valid = (state_q != ST_EMPTY);
    assign accept  = in_valid & in_ready;
    assign drain   = m_valid & out_ready;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;

        if (flush) begin
            // Everything held or arriving this cycle is dropped; payload
            // registers are left alone since ctl_out gating hides them.
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        m_d     = in_ent;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        m_d = in_ent;
                    end else if (accept) begin
                        s_d     = in_ent;
                        state_d = ST_FULL;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so no accept can coincide.
                    if (drain) begin
                        m_d     = s_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        // Registered ready: next-cycle readiness depends only on next state.
        in_ready_d = (state_d != ST_FULL);
    end

`ifdef RF_EX_PIPE_PERF_EN
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (m_valid && !out_ready) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (!m_valid) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            m_q        <= '0;
            s_q        <= '0;
            in_ready_q <= 1'b1;
`ifdef RF_EX_PIPE_PERF_EN
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            m_q        <= m_d;
            s_q        <= s_d;
            in_ready_q <= in_ready_d;
`ifdef RF_EX_PIPE_PERF_EN
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
`endif
        end
    end

    // The flop is preset during reset; masking with rst keeps ready low for
    // the whole reset window, including its first cycle.
    assign in_ready = in_ready_q & ~rst;

    assign out_valid      = m_valid;
    assign pc_out         = m_q.pc;
    assign pc2_out        = m_q.pc2;
    assign opA_out        = m_q.opa;
    assign opB_out        = m_q.opb;
    assign store_data_out = m_q.store_data;
    assign imm_eff_out    = m_q.imm_eff;
    assign ra_out         = m_q.ra;
    assign rb_out         = m_q.rb;
    assign rc_out         = m_q.rc;
    assign rf_waddr_out   = m_q.rf_waddr;
    assign ctl_out        = m_valid ? m_q.ctl : '0;

`ifdef RF_EX_PIPE_PERF_EN
    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_rf_ex_pipe.sv
// ---------------------------------------------------------------------------
// tb_rf_ex_pipe
//
// Bench for rf_ex_pipe: a table of {inputs, expected outputs} rows for the
// streaming / backpressure / flush / gating cases, backed by a scoreboard
// queue that holds the instructions expected in EX order, then a random
// phase, a mid-operation reset and (with RF_EX_PIPE_PERF_EN) counter checks.
// ---------------------------------------------------------------------------
module tb_rf_ex_pipe;

    localparam int DW    = 16;
    localparam int RW    = 3;
    localparam int CTL_W = 27;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    pc_in, pc2_in, opA_in, opB_in, store_data_in, imm_eff_in;
    logic [RW-1:0]    ra_in, rb_in, rc_in, rf_waddr_in;
    logic [CTL_W-1:0] ctl_in;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    pc_out, pc2_out, opA_out, opB_out, store_data_out, imm_eff_out;
    logic [RW-1:0]    ra_out, rb_out, rc_out, rf_waddr_out;
    logic [CTL_W-1:0] ctl_out;
`ifdef RF_EX_PIPE_PERF_EN
    logic [15:0]      stall_cnt, bubble_cnt;
`endif

    rf_ex_pipe #(.DW(DW), .RW(RW), .CTL_W(CTL_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .pc_in          (pc_in),
        .pc2_in         (pc2_in),
        .opA_in         (opA_in),
        .opB_in         (opB_in),
        .store_data_in  (store_data_in),
        .imm_eff_in     (imm_eff_in),
        .ra_in          (ra_in),
        .rb_in          (rb_in),
        .rc_in          (rc_in),
        .rf_waddr_in    (rf_waddr_in),
        .ctl_in         (ctl_in),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .pc_out         (pc_out),
        .pc2_out        (pc2_out),
        .opA_out        (opA_out),
        .opB_out        (opB_out),
        .store_data_out (store_data_out),
        .imm_eff_out    (imm_eff_out),
        .ra_out         (ra_out),
        .rb_out         (rb_out),
        .rc_out         (rc_out),
        .rf_waddr_out   (rf_waddr_out),
        .ctl_out        (ctl_out)
`ifdef RF_EX_PIPE_PERF_EN
        ,
        .stall_cnt      (stall_cnt),
        .bubble_cnt     (bubble_cnt)
`endif
    );

    typedef struct packed {
        logic [DW-1:0]    pc;
        logic [DW-1:0]    pc2;
        logic [DW-1:0]    opa;
        logic [DW-1:0]    opb;
        logic [DW-1:0]    sd;
        logic [DW-1:0]    imm;
        logic [RW-1:0]    ra;
        logic [RW-1:0]    rb;
        logic [RW-1:0]    rc;
        logic [RW-1:0]    wa;
        logic [CTL_W-1:0] ctl;
    } pay_t;

    typedef struct {
        logic             iv;
        logic             ordy;
        logic             fl;
        logic [DW-1:0]    opa;
        logic [CTL_W-1:0] ctl;
        logic             eov;
        logic             eir;
        logic [DW-1:0]    eopa;
        logic [CTL_W-1:0] ectl;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    pay_t sb[$];
    vec_t tbl[$];

    // Every payload field is derived from opA so one word identifies the
    // instruction while all fields still carry distinct bits.
    function automatic pay_t mk(input logic [DW-1:0] a, input logic [CTL_W-1:0] c);
        pay_t p;
        p.pc  = a ^ 16'h1000;
        p.pc2 = a ^ 16'h2002;
        p.opa = a;
        p.opb = ~a;
        p.sd  = a ^ 16'h5A5A;
        p.imm = {a[7:0], a[15:8]};
        p.ra  = a[2:0];
        p.rb  = a[5:3];
        p.rc  = a[8:6];
        p.wa  = a[11:9] ^ 3'b101;
        p.ctl = c;
        return p;
    endfunction

    function automatic pay_t cur();
        pay_t p;
        p.pc  = pc_out;
        p.pc2 = pc2_out;
        p.opa = opA_out;
        p.opb = opB_out;
        p.sd  = store_data_out;
        p.imm = imm_eff_out;
        p.ra  = ra_out;
        p.rb  = rb_out;
        p.rc  = rc_out;
        p.wa  = rf_waddr_out;
        p.ctl = ctl_out;
        return p;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic ordy, input logic fl, input pay_t p);
        in_valid      = iv;
        out_ready     = ordy;
        flush         = fl;
        pc_in         = p.pc;
        pc2_in        = p.pc2;
        opA_in        = p.opa;
        opB_in        = p.opb;
        store_data_in = p.sd;
        imm_eff_in    = p.imm;
        ra_in         = p.ra;
        rb_in         = p.rb;
        rc_in         = p.rc;
        rf_waddr_in   = p.wa;
        ctl_in        = p.ctl;
    endtask

    // One cycle: drive at the falling edge, compare against the scoreboard
    // shortly after, then advance the scoreboard for the coming rising edge.
    task automatic sb_step(input logic iv, input logic ordy, input logic fl, input pay_t p);
        int unsigned n;
        @(negedge clk);
        drive(iv, ordy, fl, p);
        #1;
        n = sb.size();
        check("sb_out_valid", out_valid, n > 0);
        check("sb_in_ready", in_ready, n < 2);
        if (n > 0) check("sb_payload", cur(), sb[0]);
        else       check("sb_ctl_gated", ctl_out, '0);
        if (fl) begin
            sb.delete();
        end else begin
            if (n > 0 && ordy) void'(sb.pop_front());
            if (iv && n < 2) sb.push_back(p);
        end
    endtask

    task automatic row(input logic iv, input logic ordy, input logic fl,
                       input logic [DW-1:0] opa, input logic [CTL_W-1:0] ctl,
                       input logic eov, input logic eir,
                       input logic [DW-1:0] eopa, input logic [CTL_W-1:0] ectl);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.opa = opa; v.ctl = ctl;
        v.eov = eov; v.eir = eir; v.eopa = eopa; v.ectl = ectl;
        tbl.push_back(v);
    endtask

    initial begin
        // Stream, retained data with gated ctl after drain
        row(1, 1, 0, 16'h0001, 27'h1234567, 0, 1, 16'h0000, 27'h0000000);
        row(1, 1, 0, 16'h0002, 27'h7654321, 1, 1, 16'h0001, 27'h1234567);
        row(1, 1, 0, 16'h0003, 27'h0022000, 1, 1, 16'h0002, 27'h7654321);
        row(0, 1, 0, 16'hDEAD, 27'h7FFFFFF, 1, 1, 16'h0003, 27'h0022000);
        row(0, 1, 0, 16'hDEAD, 27'h7FFFFFF, 0, 1, 16'h0003, 27'h0000000);
        // Backpressure into FULL, then release
        row(1, 0, 0, 16'h00AA, 27'h7FFFFFF, 0, 1, 16'h0003, 27'h0000000);
        row(1, 0, 0, 16'h00BB, 27'h0022000, 1, 1, 16'h00AA, 27'h7FFFFFF);
        row(1, 0, 0, 16'h00CC, 27'h5555555, 1, 0, 16'h00AA, 27'h7FFFFFF);
        row(0, 1, 0, 16'hDEAD, 27'h7FFFFFF, 1, 0, 16'h00AA, 27'h7FFFFFF);
        row(0, 1, 0, 16'hDEAD, 27'h7FFFFFF, 1, 1, 16'h00BB, 27'h0022000);
        row(0, 0, 0, 16'hDEAD, 27'h7FFFFFF, 0, 1, 16'h00BB, 27'h0000000);
        // Flush in FULL with an incoming instruction
        row(1, 0, 0, 16'h0011, 27'h0000001, 0, 1, 16'h00BB, 27'h0000000);
        row(1, 0, 0, 16'h0022, 27'h4000000, 1, 1, 16'h0011, 27'h0000001);
        row(1, 0, 1, 16'h0033, 27'h2AAAAAA, 1, 0, 16'h0011, 27'h0000001);
        row(0, 1, 0, 16'hDEAD, 27'h7FFFFFF, 0, 1, 16'h0011, 27'h0000000);
        // Flush in ONE while accepting and draining: incoming is discarded
        row(1, 0, 0, 16'h0044, 27'h0022000, 0, 1, 16'h0011, 27'h0000000);
        row(1, 1, 1, 16'h0055, 27'h3FFFFFF, 1, 1, 16'h0044, 27'h0022000);
        row(0, 1, 0, 16'hDEAD, 27'h7FFFFFF, 0, 1, 16'h0044, 27'h0000000);
        row(0, 1, 0, 16'hDEAD, 27'h7FFFFFF, 0, 1, 16'h0044, 27'h0000000);

        // ---- reset ----
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, mk(16'hBEEF, 27'h7FFFFFF));
        @(negedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_outputs_zero", cur(), '0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, mk(16'h0000, 27'h0));
        #1;
        check("rst_release_in_ready", in_ready, 1'b1);
        check("rst_release_out_valid", out_valid, 1'b0);

        // ---- table ----
        foreach (tbl[i]) begin
            sb_step(tbl[i].iv, tbl[i].ordy, tbl[i].fl, mk(tbl[i].opa, tbl[i].ctl));
            check($sformatf("row%0d_out_valid", i), out_valid, tbl[i].eov);
            check($sformatf("row%0d_in_ready", i), in_ready, tbl[i].eir);
            check($sformatf("row%0d_opA", i), opA_out, tbl[i].eopa);
            check($sformatf("row%0d_ctl", i), ctl_out, tbl[i].ectl);
        end

        // ---- random traffic with occasional flush ----
        for (int i = 0; i < 400; i++) begin
            sb_step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 15) == 0,
                    mk(16'($urandom), 27'($urandom)));
        end

        // ---- reset with flush while FULL ----
        sb_step(1'b1, 1'b0, 1'b0, mk(16'h0A0A, 27'h1111111));
        sb_step(1'b1, 1'b0, 1'b0, mk(16'h0B0B, 27'h2222222));
        sb_step(1'b1, 1'b0, 1'b0, mk(16'h0C0C, 27'h3333333));
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b1, mk(16'h0D0D, 27'h4444444));
        #1;
        check("midrst_in_ready_low", in_ready, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, mk(16'h0000, 27'h0));
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_outputs_zero", cur(), '0);
        sb.delete();
`ifdef RF_EX_PIPE_PERF_EN
        check("perf_rst_stall", stall_cnt, 16'd0);
        check("perf_rst_bubble", bubble_cnt, 16'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        // one empty cycle (accepting), then three stalled cycles
        drive(1'b1, 1'b0, 1'b0, mk(16'h0E0E, 27'h5555555));
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, mk(16'h0000, 27'h0));
        #1;
        check("post_rst_out_valid", out_valid, 1'b1);
        check("post_rst_opA", opA_out, 16'h0E0E);
        repeat (3) @(negedge clk);
`ifdef RF_EX_PIPE_PERF_EN
        #1;
        check("perf_stall_3", stall_cnt, 16'd3);
        check("perf_bubble_1", bubble_cnt, 16'd1);
`endif
        out_ready = 1'b1;
        // drain cycle, then two empty cycles
        repeat (3) @(negedge clk);
        #1;
        check("post_drain_out_valid", out_valid, 1'b0);
        check("post_drain_ctl", ctl_out, '0);
`ifdef RF_EX_PIPE_PERF_EN
        check("perf_stall_final", stall_cnt, 16'd3);
        check("perf_bubble_final", bubble_cnt, 16'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
